// File: rtl/router_pkg.sv
// Shared types and header layout for the 1x3 router packet controller.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2,
    DROP    = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Header byte = {payload_len[7:2], addr[1:0]}
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  localparam int TIMEOUT_DEFAULT = 30;
  localparam int TMO_W           = 5;

  function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
  endfunction

  function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  function automatic logic [2:0] port_onehot(input logic [1:0] addr);
    return 3'b001 << addr;
  endfunction

endpackage

// File: rtl/router_timeout.sv
// Per-port watchdog: flushes a FIFO whose valid data has gone unread for
// TIMEOUT consecutive cycles, with a one-cycle soft_reset pulse.
module router_timeout
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic fifo_empty_i,
  input  logic read_enb_i,
  output logic soft_reset_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (read_enb_i || fifo_empty_i) begin
      cnt_d = '0;
    end else if (cnt_q == TMO_W'(TIMEOUT - 1)) begin
      cnt_d   = '0;
      pulse_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign soft_reset_o = pulse_q;

endmodule

// File: rtl/router_ctrl.sv
// Packet controller for the 1x3 router: header parse, FIFO steering,
// source back-pressure, parity check and per-port unread-data flush.
module router_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic [2:0] write_enb,
  output logic       lfd_state,
  output logic       busy,
  output logic [2:0] valid_out,
  output logic [2:0] soft_reset,
  output logic       err
);

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [5:0]  len_q, len_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  par_q, par_d;
  logic        err_q, err_d;

  logic [1:0]  in_addr;
  logic [5:0]  in_len;
  logic [5:0]  cnt_inc;
  logic        accept;
  // Padded to four entries so the invalid address indexes safely.
  logic [3:0]  empty_ext, full_ext, flush_ext;

  assign in_addr   = hdr_addr(data_in);
  assign in_len    = hdr_len(data_in);
  assign cnt_inc   = cnt_q + 6'd1;
  assign empty_ext = {1'b1, fifo_empty};
  assign full_ext  = {1'b0, fifo_full};
  assign flush_ext = {1'b0, soft_reset};

  always_comb begin
    busy = 1'b0;
    case (state_q)
      IDLE:            busy = pkt_valid && (in_addr != ADDR_INVALID) && !empty_ext[in_addr];
      PAYLOAD, PARITY: busy = full_ext[sel_q];
      default:         busy = 1'b0;
    endcase
  end

  assign accept = pkt_valid && !busy;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    err_d     = err_q;
    write_enb = 3'b000;
    lfd_state = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d = in_addr;
          len_d = in_len;
          cnt_d = '0;
          if (in_addr != ADDR_INVALID) begin
            write_enb = port_onehot(in_addr);
            lfd_state = 1'b1;
            par_d     = data_in;
            err_d     = 1'b0;
            state_d   = (in_len == 6'd0) ? PARITY : PAYLOAD;
          end else begin
            err_d   = 1'b1;
            state_d = DROP;
          end
        end
      end
      PAYLOAD, PARITY: begin
        // A flush of the active FIFO abandons the packet; cnt is kept so DROP
        // discards exactly the bytes still owed by the source.
        if (flush_ext[sel_q]) begin
          err_d   = 1'b1;
          state_d = DROP;
        end else if (accept) begin
          write_enb = port_onehot(sel_q);
          if (state_q == PAYLOAD) begin
            par_d = par_q ^ data_in;
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) state_d = PARITY;
          end else begin
            err_d   = (par_q != data_in);
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (accept) begin
          if (cnt_q == len_q) state_d = IDLE;
          else                cnt_d   = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      err_q   <= err_d;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_tmo
    router_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clock        (clock),
      .reset        (reset),
      .fifo_empty_i (fifo_empty[k]),
      .read_enb_i   (read_enb[k]),
      .soft_reset_o (soft_reset[k])
    );
  end

  assign valid_out = ~fifo_empty;
  assign err       = err_q;

endmodule

// File: tb/tb_router_ctrl.sv
// Self-checking bench for router_ctrl: directed packets, randomized packets
// against a packet-level model, and per-port timeout behaviour.
module tb_router_ctrl;
  import router_pkg::*;

  localparam int T = TIMEOUT_DEFAULT;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full, fifo_empty, read_enb;
  logic [2:0] write_enb, valid_out, soft_reset;
  logic       lfd_state, busy, err;

  router_ctrl #(.TIMEOUT(T)) dut (
    .clock      (clock),
    .reset      (reset),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .read_enb   (read_enb),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .busy       (busy),
    .valid_out  (valid_out),
    .soft_reset (soft_reset),
    .err        (err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int we_cycles = 0;
  int first_acc, last_acc;

  always @(posedge clock) cyc++;
  always @(negedge clock) if (write_enb != 3'b000) we_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one byte; optionally hold it off first with a full or not-empty target.
  task automatic send_byte(input logic [7:0] b, input logic [2:0] exp_we, input logic exp_lfd,
                           input int stall, input bit stall_empty, input int port);
    pkt_valid = 1'b1;
    data_in   = b;
    if (stall > 0) begin
      if (stall_empty) fifo_empty[port] = 1'b0;
      else             fifo_full[port]  = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clock);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_we", 32'(write_enb), 32'd0);
        tick();
      end
      if (stall_empty) fifo_empty[port] = 1'b1;
      else             fifo_full[port]  = 1'b0;
    end
    @(negedge clock);
    check("acc_busy", 32'(busy), 32'd0);
    check("acc_we", 32'(write_enb), 32'(exp_we));
    check("acc_lfd", 32'(lfd_state), 32'(exp_lfd));
    last_acc = cyc;
    tick();
    pkt_valid = 1'b0;
  endtask

  task automatic gap(input int max_gap);
    int n;
    n = $urandom_range(max_gap, 0);
    pkt_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check("gap_we", 32'(write_enb), 32'd0);
      check("gap_lfd", 32'(lfd_state), 32'd0);
      check("gap_busy", 32'(busy), 32'd0);
      tick();
    end
  endtask

  // Packet-level model: every accepted byte of a routable packet lands on
  // port addr, only the header carries lfd, and err reflects the XOR check.
  task automatic send_packet(input logic [1:0] addr, input int len, input bit bad_par,
                             input int hdr_wait, input int stall_idx, input int stall_n,
                             input int max_gap);
    logic [7:0] hdr, par, b;
    logic [2:0] we;
    bit         drop;
    hdr  = {6'(len), addr};
    drop = (addr == ADDR_INVALID);
    we   = drop ? 3'b000 : 3'(1 << addr);
    par  = hdr;
    send_byte(hdr, we, !drop, drop ? 0 : hdr_wait, 1'b1, int'(addr));
    first_acc = last_acc;
    check("hdr_err", 32'(err), 32'(drop));
    for (int i = 0; i < len; i++) begin
      gap(max_gap);
      b   = 8'($urandom);
      par = par ^ b;
      send_byte(b, we, 1'b0, (!drop && i == stall_idx) ? stall_n : 0, 1'b0, int'(addr));
    end
    gap(max_gap);
    b = bad_par ? (par ^ 8'h01) : par;
    send_byte(b, we, 1'b0, (!drop && stall_idx == len) ? stall_n : 0, 1'b0, int'(addr));
    check("pkt_err", 32'(err), 32'(drop || bad_par));
  endtask

  initial begin
    int since;
    reset      = 1'b1;
    pkt_valid  = 1'b0;
    data_in    = 8'h00;
    fifo_full  = 3'b000;
    fifo_empty = 3'b111;
    read_enb   = 3'b000;
    repeat (3) tick();
    reset = 1'b0;

    @(negedge clock);
    check("rst_we", 32'(write_enb), 32'd0);
    check("rst_lfd", 32'(lfd_state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_srst", 32'(soft_reset), 32'd0);
    check("rst_vout", 32'(valid_out), 32'd0);
    fifo_empty = 3'b101;
    #1;
    check("vout_map", 32'(valid_out), 32'b010);
    fifo_empty = 3'b111;
    tick();

    // Normal packet 8'h15: 7 consecutive writes on port 1.
    we_cycles = 0;
    send_packet(2'd1, 5, 1'b0, 0, -1, 0, 0);
    check("norm_span", 32'(last_acc - first_acc + 1), 32'd7);
    check("norm_wecyc", 32'(we_cycles), 32'd7);

    // Bad parity, then err clears on the next header.
    send_packet(2'd1, 5, 1'b1, 0, -1, 0, 0);
    send_packet(2'd0, 1, 1'b0, 0, -1, 0, 0);

    // Full stall of 3 cycles before payload byte 3.
    tick();
    we_cycles = 0;
    send_packet(2'd1, 5, 1'b0, 0, 2, 3, 0);
    check("stall_span", 32'(last_acc - first_acc + 1), 32'd10);
    check("stall_wecyc", 32'(we_cycles), 32'd7);

    // Busy target, invalid address, zero-length and maximum-length packets.
    send_packet(2'd2, 2, 1'b0, 4, -1, 0, 0);
    send_packet(2'd3, 2, 1'b0, 0, -1, 0, 0);
    send_packet(2'd0, 0, 1'b0, 0, -1, 0, 0);
    send_packet(2'd2, 63, 1'b0, 0, 62, 2, 0);

    // Reset after a parity error and mid-packet.
    send_packet(2'd2, 3, 1'b1, 0, -1, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_err", 32'(err), 32'd0);
    tick();
    send_byte(8'h0D, 3'b010, 1'b1, 0, 1'b0, 1);
    send_byte(8'hA5, 3'b010, 1'b0, 0, 1'b0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    send_packet(2'd0, 2, 1'b0, 0, -1, 0, 0);

    // Flush of the active port mid-payload diverts the rest of the packet to DROP.
    send_byte(8'h10, 3'b001, 1'b1, 0, 1'b0, 0);
    send_byte(8'h11, 3'b001, 1'b0, 0, 1'b0, 0);
    send_byte(8'h22, 3'b001, 1'b0, 0, 1'b0, 0);
    fifo_empty[0] = 1'b0;
    for (int i = 1; i <= T; i++) begin
      tick();
      check("flush_pulse", 32'(soft_reset[0]), 32'(i == T));
    end
    fifo_empty[0] = 1'b1;
    tick();
    check("flush_err", 32'(err), 32'd1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 3'b000, 1'b0, 0, 1'b0, 0);
    send_packet(2'd1, 1, 1'b0, 0, -1, 0, 0);

    // Randomized packets.
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(7, 0);
      send_packet(2'($urandom_range(3, 0)), len, ($urandom_range(3, 0) == 0),
                  $urandom_range(2, 0), $urandom_range(len, 0), $urandom_range(2, 0), 2);
      gap(3);
    end

    // Timeout on port 0 with no reads: pulse exactly T edges after data appears.
    tick();
    fifo_empty[0] = 1'b0;
    for (int i = 1; i <= T + 2; i++) begin
      tick();
      check("tmo_plain", 32'(soft_reset[0]), 32'(i == T));
    end
    check("tmo_others", 32'(soft_reset[2:1]), 32'd0);
    fifo_empty[0] = 1'b1;
    tick();

    // Reads at 20 and at the would-be pulse edge 50 postpone the flush to 80.
    fifo_empty[0] = 1'b0;
    since = 0;
    for (int i = 1; i <= 85; i++) begin
      bit rd, exp;
      rd = (i == 20) || (i == 50);
      read_enb[0] = rd;
      since = rd ? 0 : since + 1;
      exp = (since == T);
      if (exp) since = 0;
      tick();
      check("tmo_read", 32'(soft_reset[0]), 32'(exp));
    end
    read_enb[0]   = 1'b0;
    fifo_empty[0] = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/router_ctrl.md
# router_ctrl

Packet-level controller for the 1x3 router. It parses the header of each incoming byte stream, steers the header, payload and parity bytes into one of the three output FIFOs, and holds the source off with `busy` while the target FIFO cannot accept data. It also checks packet parity and flushes any output FIFO whose reader leaves valid data unread for too long. It sits between the input port and the three `router_fifo` instances and drives their `write_enb`, `lfd_state` and `soft_reset` pins.

## Interface
- `TIMEOUT`, default 30: number of consecutive unread-valid cycles before a port's `soft_reset` fires.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pkt_valid` in 1: the source presents a byte on `data_in`.
- `data_in` in 8: packet byte. The header is laid out as {payload_len[7:2], addr[1:0]}.
- `fifo_full` in 3: full flag, one bit per output FIFO.
- `fifo_empty` in 3: empty flag, one bit per output FIFO.
- `read_enb` in 3: downstream read enables, one bit per port.
- `write_enb` out 3: one-hot write strobe to the FIFOs. Combinational.
- `lfd_state` out 1: marks the header write. Combinational.
- `busy` out 1: stall to the source. Combinational.
- `valid_out` out 3: equals ~`fifo_empty`.
- `soft_reset` out 3: per-FIFO flush pulse. Registered.
- `err` out 1: parity or drop error. Registered, held until the next header is accepted.

## Operation
- Accept rule: a byte is consumed at a rising edge when `pkt_valid & ~busy`. The source must hold `data_in` stable while `busy`=1. A gap in `pkt_valid` stalls the FSM in place.
- Internal registers:
  - `sel` (2b): latched target address.
  - `len` (6b): latched payload length.
  - `cnt` (6b): payload bytes consumed.
  - `par` (8b): running XOR of header and payload bytes.
- IDLE
  - `busy` = `pkt_valid` & addr≠3 & ~`fifo_empty[addr]`, where addr = `data_in[1:0]`. Headers wait until the target FIFO is fully empty.
  - On accepting a header with addr<3:
    - Outputs: `write_enb[addr]`=1 and `lfd_state`=1.
    - Latch `sel`, `len`; set `par`=header; `cnt`=0; `err`<=0.
    - Next state is PAYLOAD, or PARITY if len=0.
  - On accepting a header with addr=3: no write; `err`<=1; next state DROP.
- PAYLOAD
  - `busy` = `fifo_full[sel]`.
  - On accept: `write_enb[sel]`=1, `par`^=`data_in`, `cnt`++.
  - When the accepted byte makes `cnt`+1=`len`, next state is PARITY.
- PARITY
  - `busy` = `fifo_full[sel]`.
  - On accept: `write_enb[sel]`=1; `err`<=(`par`≠`data_in`); next state IDLE.
- DROP
  - `busy`=0; bytes are consumed without any write.
  - After `len` payload bytes plus 1 parity byte (counted with `cnt`), next state IDLE.
- Outside the accept condition, `write_enb` and `lfd_state` are 0.
- Soft reset of the active port: if `soft_reset[sel]` asserts while in PAYLOAD or PARITY, the FSM moves to DROP with `cnt` preserved, and `err`<=1. The rest of the packet is discarded.
- Timeout, per port k:
  - A 5-bit counter increments each cycle that `valid_out[k]` & ~`read_enb[k]`.
  - It clears on `read_enb[k]` or `fifo_empty[k]`.
  - On the edge where the counter would reach `TIMEOUT`, `soft_reset[k]`<=1 for exactly one cycle and the counter clears.

## Timing
- Reset values:
  - FSM in IDLE; `sel`, `len`, `cnt`, `par`, `err` = 0.
  - `soft_reset`=000; timeout counters = 0.
  - With `pkt_valid`=0: `write_enb`=000, `lfd_state`=0, `busy`=0.
- Write latency is zero: `write_enb` is asserted in the same cycle as the byte on `data_in`, and the FIFO captures both at the same edge.
- An unstalled packet of len N occupies N+2 consecutive cycles.
- `err` updates at the edge that accepts the parity byte, or the addr=3 header, and is visible the next cycle.
- `busy` has a combinational path from `pkt_valid`, `data_in[1:0]`, `fifo_full` and `fifo_empty`. No combinational path exists from `busy` back to those inputs.
- Simultaneous events:
  - `fifo_full[sel]` and `pkt_valid` in the same cycle: the byte is not accepted, and state, `cnt` and `par` are unchanged.
  - `read_enb[k]` in the cycle the counter hits `TIMEOUT`-1: the counter clears and no pulse is issued.
- Reset mid-packet: on the next edge everything returns to reset values. Partial FIFO contents are the FIFO's responsibility.

## Structure
- Package `router_pkg` holds:
  - The state enum (IDLE, PAYLOAD, PARITY, DROP).
  - `ADDR_INVALID`=2'b11.
  - The header field slice positions.
  - The default `TIMEOUT`.
- Sub-module `router_timeout`: one counter plus the pulse logic. It is instantiated three times, one per port.
- The FSM and parity logic stay in `router_ctrl`.

## Test plan
- Normal packet:
  - Stimulus: all FIFOs empty; header 8'h15 (len 5, addr 1), 5 random payload bytes, correct parity.
  - Response: `write_enb`=010 for 7 consecutive cycles; `lfd_state`=1 only on the first; `err`=0; FSM returns to IDLE.
- Bad parity:
  - Stimulus: same packet with the parity byte XOR 8'h01.
  - Response: `err`=1 from the cycle after parity; it clears when the next header is accepted.
- Full stall:
  - Stimulus: `fifo_full[1]`=1 for 3 cycles after payload byte 2.
  - Response: `busy`=1 and `write_enb`=000 for those 3 cycles; byte 3 is written on the first cycle after full drops; the packet takes 10 cycles in total.
- Busy target:
  - Stimulus: header 8'h0A (len 2, addr 2) while `fifo_empty[2]`=0.
  - Response: `busy`=1 until `fifo_empty[2]` rises; the header is then written with `lfd_state`=1.
- Invalid address:
  - Stimulus: header 8'h0B (len 2, addr 3) followed by 3 bytes.
  - Response: 4 bytes consumed with `busy`=0; `write_enb` stays 000; `err`=1.
- Timeout:
  - Stimulus: `fifo_empty[0]`=0 with `read_enb[0]`=0.
  - Response: `soft_reset[0]` pulses for 1 cycle after 30 cycles. Repeat with `read_enb[0]` pulsed at cycle 20: the pulse fires only 30 cycles after that read.
